// File: rtl/uart_tx_fifo_if.sv
// Handshake bundle between the UART word serializer/transmitter and uart_tx_fifo.
// UART_TX_FIFO_COUNT_EN adds the o_count occupancy signal.
interface uart_tx_fifo_if #(
    parameter int DATA_BITS = 8,
    parameter int ADDR_BITS = 4
);
    logic                 i_wr;
    logic [DATA_BITS-1:0] i_wr_data;
    logic                 i_rd;
    logic [DATA_BITS-1:0] o_rd_data;
    logic                 o_empty;
    logic                 o_full;
`ifdef UART_TX_FIFO_COUNT_EN
    logic [ADDR_BITS:0]   o_count;

    modport master (output i_wr, i_wr_data, i_rd,
                    input  o_rd_data, o_empty, o_full, o_count);
    modport slave  (input  i_wr, i_wr_data, i_rd,
                    output o_rd_data, o_empty, o_full, o_count);
`else
    modport master (output i_wr, i_wr_data, i_rd,
                    input  o_rd_data, o_empty, o_full);
    modport slave  (input  i_wr, i_wr_data, i_rd,
                    output o_rd_data, o_empty, o_full);
`endif
endinterface

// File: rtl/uart_tx_fifo.sv
// Show-ahead byte FIFO feeding the UART transmitter, with registered empty/full flags.
// Optional macro UART_TX_FIFO_COUNT_EN adds a registered occupancy count (o_count).
module uart_tx_fifo #(
    parameter int DATA_BITS = 8,
    parameter int ADDR_BITS = 4
) (
    input  logic          i_clk,
    input  logic          i_reset,
    uart_tx_fifo_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_BITS;

    typedef enum logic [1:0] {
        OP_IDLE  = 2'b00,
        OP_READ  = 2'b01,
        OP_WRITE = 2'b10,
        OP_BOTH  = 2'b11
    } op_e;

    logic [DATA_BITS-1:0] mem [DEPTH];
    logic [ADDR_BITS-1:0] wr_ptr;
    logic [ADDR_BITS-1:0] rd_ptr;
    logic [ADDR_BITS-1:0] wr_ptr_inc;
    logic [ADDR_BITS-1:0] rd_ptr_inc;
    logic                 empty_q;
    logic                 full_q;
    logic                 do_store;
    op_e                  op;

    assign op         = op_e'({bus.i_wr, bus.i_rd});
    assign wr_ptr_inc = wr_ptr + ADDR_BITS'(1);
    assign rd_ptr_inc = rd_ptr + ADDR_BITS'(1);

    // A full FIFO still accepts a write paired with a read: the head slot is vacated on the same edge.
    assign do_store = !i_reset && bus.i_wr && (!full_q || bus.i_rd);

    always_ff @(posedge i_clk) begin
        if (do_store) begin
            mem[wr_ptr] <= bus.i_wr_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
        end else begin
            case (op)
                OP_READ: begin
                    if (!empty_q) begin
                        rd_ptr  <= rd_ptr_inc;
                        full_q  <= 1'b0;
                        empty_q <= (rd_ptr_inc == wr_ptr);
                    end
                end
                OP_WRITE: begin
                    if (!full_q) begin
                        wr_ptr  <= wr_ptr_inc;
                        empty_q <= 1'b0;
                        full_q  <= (wr_ptr_inc == rd_ptr);
                    end
                end
                OP_BOTH: begin
                    if (empty_q) begin
                        wr_ptr  <= wr_ptr_inc;
                        empty_q <= 1'b0;
                        full_q  <= (wr_ptr_inc == rd_ptr);
                    end else begin
                        wr_ptr <= wr_ptr_inc;
                        rd_ptr <= rd_ptr_inc;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.o_rd_data = mem[rd_ptr];
    assign bus.o_empty   = empty_q;
    assign bus.o_full    = full_q;

`ifdef UART_TX_FIFO_COUNT_EN
    logic [ADDR_BITS:0] count_q;
    logic               grow;
    logic               shrink;

    // Paired read+write leaves occupancy unchanged unless the read was ignored on empty.
    assign grow   = (op == OP_WRITE && !full_q) || (op == OP_BOTH && empty_q);
    assign shrink = (op == OP_READ && !empty_q);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            count_q <= '0;
        end else if (grow) begin
            count_q <= count_q + (ADDR_BITS + 1)'(1);
        end else if (shrink) begin
            count_q <= count_q - (ADDR_BITS + 1)'(1);
        end
    end

    assign bus.o_count = count_q;
`endif
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: directed vector table, serializer sequence,
// and randomized traffic against a queue-based reference model.
module tb_uart_tx_fifo;
    localparam int DATA_BITS = 8;
    localparam int ADDR_BITS = 4;
    localparam int DEPTH     = 2 ** ADDR_BITS;

    typedef struct {
        string      name;
        logic       rst;
        logic       wr;
        logic       rd;
        logic [7:0] din;
        logic       exp_empty;
        logic       exp_full;
        logic       chk_data;
        logic [7:0] exp_data;
    } vec_t;

    logic i_clk;
    logic i_reset;
    int   count_compared;
    int   count_mismatched;
    vec_t vecs[$];
    logic [7:0] model_q[$];

    uart_tx_fifo_if #(.DATA_BITS(DATA_BITS), .ADDR_BITS(ADDR_BITS)) bus ();

    uart_tx_fifo #(.DATA_BITS(DATA_BITS), .ADDR_BITS(ADDR_BITS)) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .bus     (bus)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    function automatic void add_vec(input string name, input logic rst, input logic wr, input logic rd,
                                    input logic [7:0] din, input logic e, input logic f,
                                    input logic chk, input logic [7:0] d);
        vec_t v;
        v.name = name; v.rst = rst; v.wr = wr; v.rd = rd; v.din = din;
        v.exp_empty = e; v.exp_full = f; v.chk_data = chk; v.exp_data = d;
        vecs.push_back(v);
    endfunction

    // Reference: pop first if anything is held, then push if there is room.
    function automatic void model_step(input logic rst, input logic wr, input logic rd, input logic [7:0] din);
        if (rst) begin
            model_q.delete();
        end else begin
            if (rd && model_q.size() > 0) void'(model_q.pop_front());
            if (wr && model_q.size() < DEPTH) model_q.push_back(din);
        end
    endfunction

    task automatic checkValue(input string name, input int got, input int want);
        count_compared++;
        if (got != want) begin
            count_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic wr, input logic rd, input logic [7:0] din);
        i_reset       = rst;
        bus.i_wr      = wr;
        bus.i_rd      = rd;
        bus.i_wr_data = din;
        @(posedge i_clk);
        model_step(rst, wr, rd, din);
        #1;
        i_reset  = 1'b0;
        bus.i_wr = 1'b0;
        bus.i_rd = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic e, input logic f,
                               input logic chk, input logic [7:0] d);
        checkValue({name, ".empty"}, int'(bus.o_empty), int'(e));
        checkValue({name, ".full"}, int'(bus.o_full), int'(f));
        if (chk) checkValue({name, ".data"}, int'(bus.o_rd_data), int'(d));
`ifdef UART_TX_FIFO_COUNT_EN
        checkValue({name, ".count"}, int'(bus.o_count), model_q.size());
`endif
    endtask

    task automatic serializeWord(input logic [31:0] word);
        int waited;
        for (int b = 0; b < 4; b++) begin
            waited = 0;
            while (bus.o_full && waited < 64) begin
                applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
                waited++;
            end
            if (bus.o_full) begin
                count_compared++;
                count_mismatched++;
                $display("[TB] FAIL ser_full_wait: got full=1 after %0d cycles, expected full=0", waited);
            end
            applyStimulus(1'b0, 1'b1, 1'b0, word[8*b +: 8]);
            checkOutput("ser_wr", 1'b0, 1'b0, 1'b1, word[7:0]);
        end
        for (int b = 0; b < 4; b++) begin
            waited = 0;
            while (bus.o_empty && waited < 64) begin
                applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
                waited++;
            end
            if (bus.o_empty) begin
                count_compared++;
                count_mismatched++;
                $display("[TB] FAIL ser_empty_wait: got empty=1 after %0d cycles, expected empty=0", waited);
            end
            checkValue("ser_pop", int'(bus.o_rd_data), int'(word[8*b +: 8]));
            applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
        end
        checkOutput("ser_drained", 1'b1, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic randomPhase(input int cycles, input int wr_pct, input int rd_pct);
        logic rst, wr, rd;
        logic [7:0] din;
        for (int c = 0; c < cycles; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            wr  = ($urandom_range(0, 99) < wr_pct);
            rd  = ($urandom_range(0, 99) < rd_pct);
            din = 8'($urandom);
            applyStimulus(rst, wr, rd, din);
            checkOutput("rand", model_q.size() == 0, model_q.size() == DEPTH,
                        model_q.size() != 0, (model_q.size() != 0) ? model_q[0] : 8'h00);
        end
    endtask

    initial begin
        logic [7:0] tail [16];
        count_compared   = 0;
        count_mismatched = 0;
        i_reset          = 1'b1;
        bus.i_wr         = 1'b0;
        bus.i_rd         = 1'b0;
        bus.i_wr_data    = 8'h00;

        add_vec("reset0", 1, 0, 0, 8'h00, 1, 0, 0, 8'h00);
        add_vec("reset1", 1, 0, 0, 8'h00, 1, 0, 0, 8'h00);
        add_vec("rd_empty0", 0, 0, 1, 8'h00, 1, 0, 0, 8'h00);
        add_vec("rd_empty1", 0, 0, 1, 8'h00, 1, 0, 0, 8'h00);
        add_vec("wr_a5", 0, 1, 0, 8'hA5, 0, 0, 1, 8'hA5);
        add_vec("rd_a5", 0, 0, 1, 8'h00, 1, 0, 0, 8'h00);
        for (int i = 0; i < 16; i++)
            add_vec("fill", 0, 1, 0, 8'(i), 0, (i == 15), 1, 8'h00);
        add_vec("wr_drop", 0, 1, 0, 8'hFF, 0, 1, 1, 8'h00);
        for (int i = 0; i < 16; i++)
            add_vec("drain", 0, 0, 1, 8'h00, (i == 15), 0, (i < 15), 8'(i + 1));
        for (int i = 0; i < 10; i++)
            add_vec("pre_wr", 0, 1, 0, 8'(8'h80 + i), 0, 0, 1, 8'h80);
        for (int i = 0; i < 10; i++)
            add_vec("pre_rd", 0, 0, 1, 8'h00, (i == 9), 0, (i < 9), 8'(8'h81 + i));
        for (int i = 0; i < 16; i++)
            add_vec("wrap_fill", 0, 1, 0, 8'(8'h10 + i), 0, (i == 15), 1, 8'h10);
        add_vec("rw_full", 0, 1, 1, 8'h55, 0, 1, 1, 8'h11);
        for (int i = 0; i < 15; i++) tail[i] = 8'(8'h11 + i);
        tail[15] = 8'h55;
        for (int i = 0; i < 16; i++)
            add_vec("wrap_drain", 0, 0, 1, 8'h00, (i == 15), 0, (i < 15), tail[(i + 1) % 16]);
        add_vec("rw_empty", 0, 1, 1, 8'h3C, 0, 0, 1, 8'h3C);
        add_vec("rd_3c", 0, 0, 1, 8'h00, 1, 0, 0, 8'h00);
        for (int i = 0; i < 5; i++)
            add_vec("pre_rst", 0, 1, 0, 8'(8'h40 + i), 0, 0, 1, 8'h40);
        add_vec("rst_wr", 1, 1, 0, 8'h99, 1, 0, 0, 8'h00);
        add_vec("wr_7e", 0, 1, 0, 8'h7E, 0, 0, 1, 8'h7E);
        add_vec("rd_7e", 0, 0, 1, 8'h00, 1, 0, 0, 8'h00);

        #2;
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rst, vecs[i].wr, vecs[i].rd, vecs[i].din);
            checkOutput(vecs[i].name, vecs[i].exp_empty, vecs[i].exp_full,
                        vecs[i].chk_data, vecs[i].exp_data);
        end

        serializeWord(32'hDEADBEEF);

        randomPhase(600, 75, 30);
        randomPhase(600, 30, 75);
        randomPhase(600, 50, 50);
        randomPhase(300, 95, 95);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", count_compared, count_mismatched);
        $finish;
    end
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Byte FIFO between the debugger's UART word serializer and the UART transmitter.
- Write side: accepts single-cycle write pulses of one byte each from the serializer and reports a registered full flag. The serializer polls this flag before every write.
- Read side: presents the oldest byte to the transmitter in show-ahead mode. The transmitter pops one byte per read pulse.
- Absorbs bursts, e.g. a 32-bit debug word emitted as 4 back-to-back bytes, while the serial line drains at baud rate.

Parameters:
DATA_BITS, 8, width of one FIFO entry (the UART byte)
ADDR_BITS, 4, pointer width; depth = 2**ADDR_BITS = 16 entries

Ports:
i_clk  input  1  system clock; all logic on rising edge
i_reset  input  1  synchronous, active-high reset
i_wr  input  1  write strobe; one entry pushed per cycle it is high
i_wr_data  input  DATA_BITS  byte to push, sampled when i_wr high
i_rd  input  1  read strobe; pops current head entry per cycle it is high
o_rd_data  output  DATA_BITS  head entry (show-ahead); valid only while o_empty low
o_empty  output  1  registered; high when FIFO holds 0 entries
o_full  output  1  registered; high when FIFO holds 2**ADDR_BITS entries

Behaviour:
- Clock and reset: one clock domain (i_clk). Reset is synchronous and active-high (i_reset).
- Reset values:
  - write pointer = 0, read pointer = 0
  - o_empty = 1, o_full = 0
  - storage array not reset; o_rd_data is don't-care while o_empty = 1
- Storage:
  - 2**ADDR_BITS x DATA_BITS register array, written synchronously at mem[wr_ptr].
  - o_rd_data = mem[rd_ptr], combinational from the array and read pointer. There is no output register.
- Pointers:
  - ADDR_BITS wide; increment modulo 2**ADDR_BITS, with natural wrap from 2**ADDR_BITS-1 to 0.
  - Full/empty are held in separate status registers, not derived from an extra pointer bit.
- Registered, state-machine-style next-state logic, decided on {i_wr, i_rd} each cycle:
  - 00: no change.
  - 01 (read only):
    - If !o_empty: rd_ptr+1; o_full_next = 0; o_empty_next = 1 when rd_ptr+1 == wr_ptr.
    - If o_empty: ignored, no underflow, pointers unchanged.
  - 10 (write only):
    - If !o_full: store i_wr_data; wr_ptr+1; o_empty_next = 0; o_full_next = 1 when wr_ptr+1 == rd_ptr.
    - If o_full: write dropped silently; pointers and flags unchanged.
  - 11 (read and write):
    - If o_empty: write only (the read is ignored). o_empty becomes 0, and o_rd_data shows the new byte the next cycle.
    - Otherwise, including when full: store, then advance both pointers. Flags are unchanged and data order is preserved.
- Latency and handshake:
  - A byte written at edge N is visible on o_rd_data with o_empty = 0 after edge N.
  - o_full updates on the same edge as the write that fills the FIFO. A writer that samples o_full in the cycle after its write pulse therefore always sees the current state.
  - The serializer pattern (check !o_full, pulse i_wr for one cycle, recheck) can never overflow.
- Throughput: one push and/or one pop per cycle; no bubbles.
- Reset mid-operation: i_reset high at any edge discards all contents. It overrides simultaneous i_wr/i_rd, and the FIFO is empty on the following cycle.

Optional Feature:
Macro UART_TX_FIFO_COUNT_EN.
- Defined:
  - Adds output o_count, width ADDR_BITS+1, a registered occupancy count, reset value 0.
  - Update rule: +1 on an accepted write only, -1 on an accepted read only, unchanged on an accepted read+write or on dropped operations.
  - Always equals the number of stored entries: 0 when o_empty is high, 2**ADDR_BITS when o_full is high.
- Not defined: port and counter absent; all other behaviour identical.

Test Plan:
1. Apply i_reset for 2 cycles, then release -> o_empty = 1, o_full = 0 (o_count = 0 when enabled); i_rd pulses while empty leave the flags unchanged.
2. Pulse i_wr with 0xA5 -> next cycle o_empty = 0, o_rd_data = 0xA5. Pulse i_rd -> next cycle o_empty = 1.
3. Write 0x00..0x0F on consecutive cycles -> o_full = 1 right after the 16th write; a 17th write of 0xFF is dropped. Read 16 times -> bytes 0x00..0x0F in order; o_empty = 1 after the last read; 0xFF never appears.
4. Wrap-around: write 10 bytes and read 10, then write 0x10..0x1F (16 bytes, crossing index 15 to 0) -> o_full = 1; read-back yields 0x10..0x1F in order.
5. Simultaneous i_wr/i_rd:
   - When full, writing 0x55 -> o_full stays 1; the head advances, and 0x55 emerges last.
   - When empty, writing 0x3C -> o_empty = 0 and o_rd_data = 0x3C next cycle.
6. Store 5 bytes, then assert i_reset for one cycle together with i_wr = 1 -> o_empty = 1, o_full = 0. A following write/read of 0x7E returns 0x7E. Drive the serializer model sending a 32-bit word 0xDEADBEEF -> bytes EF, BE, AD, DE popped in order.
